// File: rtl/ptb2_quad_seq_engine.sv
// rtl/ptb2_quad_seq_engine.sv - three-term window classifier and next-term predictor
module ptb2_quad_seq_engine (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_write_en,
    input  logic       i_read_en,
    input  logic [4:0] i_data,
    output logic [1:0] o_result,
    output logic [3:0] o_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIFF = 2'd1,
        S_SEC  = 2'd2,
        S_NEXT = 2'd3
    } state_t;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_ARITH = 2'b01;
    localparam logic [1:0] RES_QUAD  = 2'b10;
    localparam logic [1:0] RES_INVAL = 2'b11;

    state_t             r_state;
    logic signed [4:0]  r_t0;
    logic signed [4:0]  r_t1;
    logic signed [4:0]  r_t2;
    logic        [1:0]  r_cnt;
    logic signed [5:0]  r_d1;
    logic signed [5:0]  r_d2;
    logic signed [6:0]  r_s;
    logic        [1:0]  r_result;
    logic        [3:0]  r_data;

    logic signed [7:0]  w_n;

    // Prediction is formed combinationally in NEXT so the result lands on the NEXT->IDLE edge.
    assign w_n = $signed({{3{r_t2[4]}}, r_t2}) + $signed({{2{r_d2[5]}}, r_d2})
               + $signed({r_s[6], r_s});

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_t0     <= '0;
            r_t1     <= '0;
            r_t2     <= '0;
            r_cnt    <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_s      <= '0;
            r_result <= RES_NONE;
            r_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_write_en) begin
                        r_t0     <= r_t1;
                        r_t1     <= r_t2;
                        r_t2     <= i_data;
                        r_cnt    <= (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
                        r_result <= RES_NONE;
                        r_data   <= '0;
                    end else if (i_read_en) begin
                        r_result <= RES_NONE;
                        r_state  <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    r_d1    <= $signed({r_t1[4], r_t1}) - $signed({r_t0[4], r_t0});
                    r_d2    <= $signed({r_t2[4], r_t2}) - $signed({r_t1[4], r_t1});
                    r_state <= S_SEC;
                end
                S_SEC: begin
                    r_s     <= $signed({r_d2[5], r_d2}) - $signed({r_d1[5], r_d1});
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_cnt != 2'd3) begin
                        r_result <= RES_INVAL;
                        r_data   <= 4'd0;
                    end else if (w_n > 8'sd7) begin
                        r_result <= RES_INVAL;
                        r_data   <= 4'd7;
                    end else if (w_n < -8'sd8) begin
                        r_result <= RES_INVAL;
                        r_data   <= 4'b1000;
                    end else begin
                        r_result <= (r_s == 7'sd0) ? RES_ARITH : RES_QUAD;
                        r_data   <= w_n[3:0];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_result = r_result;
    assign o_data   = r_data;

endmodule

// File: tb/tb_ptb2_quad_seq_engine.sv
// tb/tb_ptb2_quad_seq_engine.sv - scoreboard bench for ptb2_quad_seq_engine
module tb_ptb2_quad_seq_engine;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_write_en;
    logic       i_read_en;
    logic [4:0] i_data;
    logic [1:0] o_result;
    logic [3:0] o_data;

    ptb2_quad_seq_engine u_dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_write_en (i_write_en),
        .i_read_en  (i_read_en),
        .i_data     (i_data),
        .o_result   (o_result),
        .o_data     (o_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int res;
        int dat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_t0, m_t1, m_t2, m_cnt;
    logic [1:0] prev_result = 2'b00;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic exp_t predict();
        exp_t e;
        int d1, d2, s, n;
        d1 = m_t1 - m_t0;
        d2 = m_t2 - m_t1;
        s  = d2 - d1;
        n  = m_t2 + d2 + s;
        if (m_cnt < 3) begin e.res = 3; e.dat = 0; end
        else if (n > 7) begin e.res = 3; e.dat = 7; end
        else if (n < -8) begin e.res = 3; e.dat = 8; end
        else begin e.res = (s == 0) ? 1 : 2; e.dat = n & 15; end
        return e;
    endfunction

    // Monitor: a fresh result appears as o_result leaving 00.
    always @(negedge i_clk) begin
        if (i_rst_n && o_result != 2'b00 && prev_result == 2'b00) begin
            if (sb.size() == 0) begin
                check_eq("spurious_result", int'(o_result), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", int'(o_result), e.res);
                check_eq("data", int'(o_data), e.dat);
            end
        end
        prev_result = o_result;
    end

    task automatic model_shift(input int v);
        m_t0 = m_t1; m_t1 = m_t2; m_t2 = v;
        if (m_cnt < 3) m_cnt++;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_t0 = 0; m_t1 = 0; m_t2 = 0; m_cnt = 0;
    endtask

    task automatic do_write(input int v);
        logic [31:0] vb;
        vb = v;
        @(negedge i_clk);
        i_write_en = 1'b1;
        i_data     = vb[4:0];
        @(negedge i_clk);
        i_write_en = 1'b0;
        model_shift(v);
        #1;
        check_eq("write_clears_result", int'(o_result), 0);
    endtask

    task automatic wait_result();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 10) begin
            @(negedge i_clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            check_eq("timeout_pending", sb.size(), 0);
            sb.delete();
        end else begin
            check_eq("read_latency", k, 3);
        end
    endtask

    task automatic do_read(input logic busy_write);
        @(negedge i_clk);
        i_read_en = 1'b1;
        sb.push_back(predict());
        @(negedge i_clk);
        i_read_en = 1'b0;
        #1;
        check_eq("busy_at_E", int'(o_result), 0);
        if (busy_write) begin
            i_write_en = 1'b1;
            i_data     = 5'd9;
            @(negedge i_clk);
            i_write_en = 1'b0;
            #1;
            // DUT is busy: write ignored, model untouched; one cycle of latency already spent
            if (sb.size() != 0) begin
                int k;
                k = 1;
                while (sb.size() != 0 && k < 10) begin
                    @(negedge i_clk);
                    #1;
                    k++;
                end
                check_eq("busy_latency", k, 3);
                if (sb.size() != 0) sb.delete();
            end
        end else begin
            wait_result();
        end
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_write_en = 1'b0;
        i_read_en  = 1'b0;
        i_data     = '0;
        m_t0 = 0; m_t1 = 0; m_t2 = 0; m_cnt = 0;
        repeat (2) @(negedge i_clk);
        check_eq("reset_result", int'(o_result), 0);
        check_eq("reset_data", int'(o_data), 0);
        i_rst_n = 1'b1;

        do_write(1); do_write(3); do_write(5); do_read(1'b0);
        do_write(1); do_write(2); do_write(4); do_read(1'b0);
        do_write(9); do_write(1); do_write(3); do_write(5); do_read(1'b0);

        do_reset();
        do_write(5); do_write(6); do_read(1'b0);
        do_write(7); do_read(1'b0);
        do_write(-1); do_write(-5); do_write(-12); do_read(1'b0);
        do_write(-2); do_write(-4); do_write(-6); do_read(1'b0);

        do_write(1); do_write(2); do_write(4);
        do_read(1'b1);
        do_read(1'b0);

        // Write and read together in IDLE: write wins, no computation starts.
        @(negedge i_clk);
        i_write_en = 1'b1;
        i_read_en  = 1'b1;
        i_data     = 5'd8;
        @(negedge i_clk);
        i_write_en = 1'b0;
        i_read_en  = 1'b0;
        model_shift(8);
        #1;
        check_eq("simul_result", int'(o_result), 0);
        repeat (4) @(negedge i_clk);
        #1;
        check_eq("simul_no_calc", int'(o_result), 0);
        do_read(1'b0);

        do_write(1); do_write(3); do_write(5);
        @(negedge i_clk);
        i_read_en = 1'b1;
        @(negedge i_clk);
        i_read_en = 1'b0;
        i_rst_n   = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_t0 = 0; m_t1 = 0; m_t2 = 0; m_cnt = 0;
        #1;
        check_eq("midreset_result", int'(o_result), 0);
        check_eq("midreset_data", int'(o_data), 0);
        repeat (4) @(negedge i_clk);
        #1;
        check_eq("midreset_no_result", int'(o_result), 0);
        do_read(1'b0);

        for (int i = 0; i < 12; i++) begin
            do_write(int'($urandom_range(0, 31)) - 16);
            if (i % 3 == 2) do_read(1'b0);
        end

        repeat (3) @(negedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
